conv_transposed_2d_zero_insert_pad: RTL and testbench

Upstream feeder for the transposed-2D-convolution stage (square input, asymmetric kernel). Takes a square input feature map as a raster stream and emits the stride-dilated, kernel-padded map on which the downstream stage runs an ordinary stride-1 convolution. Stride zero-insertion and padding (KH-1-PAD rows, KW-1-PAD columns, OUT_PAD extra bottom/right) are done on the fly with ready/valid flow control, with no frame buffer.

---
 rtl/conv_t2d_pkg.sv | 25 ++
 rtl/stride_pad_axis_counter.sv | 31 +++
 rtl/conv_transposed_2d_zero_insert_pad.sv | 63 ++++++
 tb/tb_conv_transposed_2d_zero_insert_pad.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/conv_t2d_pkg.sv
// conv_t2d_pkg: geometry helpers and state type for the transposed-conv zero-insert/pad feeder
package conv_t2d_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic int pad_top(int kh, int pad);
    return kh - 1 - pad;
  endfunction
  function automatic int pad_left(int kw, int pad);
    return kw - 1 - pad;
  endfunction
  function automatic int pad_bottom(int kh, int pad, int out_pad);
    return kh - 1 - pad + out_pad;
  endfunction
  function automatic int pad_right(int kw, int pad, int out_pad);
    return kw - 1 - pad + out_pad;
  endfunction
  function automatic int out_h(int n, int s, int kh, int pad, int out_pad);
    return (n - 1) * s + 1 + pad_top(kh, pad) + pad_bottom(kh, pad, out_pad);
  endfunction
  function automatic int out_w(int n, int s, int kw, int pad, int out_pad);
    return (n - 1) * s + 1 + pad_left(kw, pad) + pad_right(kw, pad, out_pad);
  endfunction
  function automatic int ctr_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/stride_pad_axis_counter.sv
// stride_pad_axis_counter: position along one axis of the dilated/padded map, with stride phase
module stride_pad_axis_counter import conv_t2d_pkg::*; #(
  parameter int SIZE = 4,
  parameter int S = 2,
  parameter int PRE = 0,
  parameter int POST = 0,
  localparam int LEN = (SIZE - 1) * S + 1 + PRE + POST,
  localparam int PW = ctr_w(LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step,
  output logic [PW-1:0] pos,
  output logic          is_real,
  output logic          last
);
  localparam int SW = ctr_w(S);
  localparam int LAST_REAL = PRE + (SIZE - 1) * S;
  logic [SW-1:0] phase;
  assign last = pos == PW'(LEN - 1);
  assign is_real = int'(pos) >= PRE && int'(pos) <= LAST_REAL && phase == '0;
  // phase stays 0 through the leading pad so it reads 0 exactly at the first real position
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pos <= '0;
      phase <= '0;
    end else if (step) begin
      pos <= last ? '0 : pos + 1'b1;
      phase <= (last || int'(pos) < PRE || phase == SW'(S - 1)) ? '0 : phase + 1'b1;
    end
endmodule

// File: rtl/conv_transposed_2d_zero_insert_pad.sv
// conv_transposed_2d_zero_insert_pad: streams a square map out stride-dilated and kernel-padded,
// inserting zeros on the fly with ready/valid flow control.
module conv_transposed_2d_zero_insert_pad import conv_t2d_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int IN_SIZE = 4,
  parameter int STRIDE = 2,
  parameter int KH = 3,
  parameter int KW = 2,
  parameter int PAD = 0,
  parameter int OUT_PAD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [DATA_W-1:0] input_data,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [DATA_W-1:0] output_data,
  output logic              sof_out,
  output logic              eol_out,
  output logic              eof_out
);
  localparam int PT = pad_top(KH, PAD);
  localparam int PL = pad_left(KW, PAD);
  localparam int PB = pad_bottom(KH, PAD, OUT_PAD);
  localparam int PR = pad_right(KW, PAD, OUT_PAD);
  localparam int RW = ctr_w(out_h(IN_SIZE, STRIDE, KH, PAD, OUT_PAD));
  localparam int CW = ctr_w(out_w(IN_SIZE, STRIDE, KW, PAD, OUT_PAD));
  state_t state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic row_real, col_real, row_last, col_last, is_real, room, adv;
  assign is_real = row_real && col_real;
  assign room = !valid_out || ready_in;
  assign adv = state == RUN && room && (!is_real || valid_in);
  assign ready_out = state == RUN && is_real && room;
  stride_pad_axis_counter #(.SIZE(IN_SIZE), .S(STRIDE), .PRE(PL), .POST(PR)) u_col (
    .clk(clk), .rst_n(rst_n), .step(adv), .pos(col), .is_real(col_real), .last(col_last)
  );
  stride_pad_axis_counter #(.SIZE(IN_SIZE), .S(STRIDE), .PRE(PT), .POST(PB)) u_row (
    .clk(clk), .rst_n(rst_n), .step(adv && col_last), .pos(row), .is_real(row_real), .last(row_last)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      valid_out <= 1'b0;
      output_data <= '0;
      sof_out <= 1'b0;
      eol_out <= 1'b0;
      eof_out <= 1'b0;
    end else begin
      if (adv) begin
        valid_out <= 1'b1;
        output_data <= is_real ? input_data : '0;
        sof_out <= row == '0 && col == '0;
        eol_out <= col_last;
        eof_out <= row_last && col_last;
      end else if (ready_in)
        valid_out <= 1'b0;
      state <= state == IDLE ? (valid_in ? RUN : IDLE) : (adv && row_last && col_last ? IDLE : RUN);
    end
endmodule

// File: tb/tb_conv_transposed_2d_zero_insert_pad.sv
// tb_conv_transposed_2d_zero_insert_pad: directed scenarios over three geometries of the feeder
module tb_conv_transposed_2d_zero_insert_pad;
  logic clk = 1'b0, rst_n = 1'b0, valid_in = 1'b0, ready_in = 1'b1;
  logic [31:0] input_data = '0;
  logic ro[3], vo[3], sof[3], eol[3], eof[3];
  logic [31:0] od[3];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;

  conv_transposed_2d_zero_insert_pad #(.DATA_W(32), .IN_SIZE(2), .STRIDE(2), .KH(3), .KW(2), .PAD(0), .OUT_PAD(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ro[0]), .input_data(input_data),
    .valid_out(vo[0]), .ready_in(ready_in), .output_data(od[0]), .sof_out(sof[0]), .eol_out(eol[0]), .eof_out(eof[0]));
  conv_transposed_2d_zero_insert_pad #(.DATA_W(32), .IN_SIZE(3), .STRIDE(1), .KH(1), .KW(3), .PAD(0), .OUT_PAD(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ro[1]), .input_data(input_data),
    .valid_out(vo[1]), .ready_in(ready_in), .output_data(od[1]), .sof_out(sof[1]), .eol_out(eol[1]), .eof_out(eof[1]));
  conv_transposed_2d_zero_insert_pad #(.DATA_W(32), .IN_SIZE(2), .STRIDE(3), .KH(2), .KW(2), .PAD(1), .OUT_PAD(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ro[2]), .input_data(input_data),
    .valid_out(vo[2]), .ready_in(ready_in), .output_data(od[2]), .sof_out(sof[2]), .eol_out(eol[2]), .eof_out(eof[2]));

  task automatic do_reset();
    rst_n = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Drives nfr frames into one DUT and checks every transferred output against the geometry.
  task automatic test_stream(input int sel, input int nfr, input int gap, input bit bp, input int base, input string name);
    int n, s, pt, pl, h, w, fsz, in_i, out_i, gapc, cyc, lc, k, r, c, f;
    logic [31:0] ed, pd;
    logic [2:0] ef, pf, gf;
    bit pv, pr, rl;
    case (sel)
      0: begin n = 2; s = 2; pt = 2; pl = 1; h = 7; w = 5; end
      1: begin n = 3; s = 1; pt = 0; pl = 2; h = 3; w = 7; end
      default: begin n = 2; s = 3; pt = 0; pl = 0; h = 6; w = 6; end
    endcase
    fsz = h * w; in_i = 0; out_i = 0; gapc = 0; cyc = 0; lc = 0; pv = 0; pr = 1; pd = '0; pf = '0;
    while (out_i < nfr * fsz && cyc < 4000) begin
      @(negedge clk);
      ready_in = bp ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
      if (in_i < nfr * n * n && gapc >= gap) begin
        valid_in = 1'b1;
        input_data = 32'(base + in_i);
      end else begin
        valid_in = 1'b0;
        gapc++;
      end
      #1;
      gf = {sof[sel], eol[sel], eof[sel]};
      if (pv && !pr) begin
        tests++;
        if (vo[sel] !== 1'b1 || od[sel] !== pd || gf !== pf) begin
          fails++;
          $display("FAIL %s hold cyc %0d: got v=%b d=%0d f=%b, need v=1 d=%0d f=%b", name, cyc, vo[sel], od[sel], gf, pd, pf);
        end
      end
      pv = vo[sel]; pr = ready_in; pd = od[sel]; pf = gf;
      if (vo[sel] === 1'b1 && ready_in) begin
        f = out_i / fsz; k = out_i % fsz; r = k / w; c = k % w;
        rl = r >= pt && r <= pt + (n - 1) * s && (r - pt) % s == 0 && c >= pl && c <= pl + (n - 1) * s && (c - pl) % s == 0;
        ed = rl ? 32'(base + f * n * n + ((r - pt) / s) * n + (c - pl) / s) : 32'd0;
        ef = {k == 0, c == w - 1, k == fsz - 1};
        tests++;
        if (od[sel] !== ed || gf !== ef) begin
          fails++;
          $display("FAIL %s out[%0d] (r%0d,c%0d): got d=%0d f=%b, need d=%0d f=%b", name, out_i, r, c, od[sel], gf, ed, ef);
        end
        if (gap == 0 && !bp && out_i > 0) begin
          tests++;
          if (cyc - lc != (k == 0 ? 2 : 1)) begin
            fails++;
            $display("FAIL %s spacing out[%0d]: got %0d cycles, need %0d", name, out_i, cyc - lc, k == 0 ? 2 : 1);
          end
        end
        lc = cyc;
        out_i++;
      end
      if (valid_in && ro[sel]) begin
        in_i++;
        gapc = 0;
      end
      cyc++;
    end
    valid_in = 1'b0;
    tests++;
    if (out_i != nfr * fsz || in_i != nfr * n * n) begin
      fails++;
      $display("FAIL %s count: got %0d out %0d in, need %0d out %0d in", name, out_i, in_i, nfr * fsz, nfr * n * n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid_in = 1'b1;
    input_data = 32'hdead;
    @(negedge clk);
    #1;
    tests++;
    if ({ro[0], vo[0], sof[0], eol[0], eof[0]} !== 5'b0 || od[0] !== 32'd0) begin
      fails++;
      $display("FAIL reset: got ro=%b vo=%b flags=%b%b%b d=%0h, need all 0", ro[0], vo[0], sof[0], eol[0], eof[0], od[0]);
    end
    valid_in = 1'b0;
  endtask

  task automatic test_latency();
    do_reset();
    valid_in = 1'b1;
    input_data = 32'd1;
    #1;
    tests++;
    if (ro[0] !== 1'b0) begin
      fails++;
      $display("FAIL idle_ready: got %b, need 0", ro[0]);
    end
    @(posedge clk); #1;
    tests++;
    if (vo[0] !== 1'b0) begin
      fails++;
      $display("FAIL latency1: got valid_out %b, need 0", vo[0]);
    end
    @(posedge clk); #1;
    tests++;
    if (vo[0] !== 1'b1 || sof[0] !== 1'b1 || od[0] !== 32'd0) begin
      fails++;
      $display("FAIL latency2: got v=%b sof=%b d=%0d, need v=1 sof=1 d=0", vo[0], sof[0], od[0]);
    end
    valid_in = 1'b0;
  endtask

  task automatic test_mid_reset();
    int cnt, cyc;
    do_reset();
    cnt = 0; cyc = 0;
    valid_in = 1'b1;
    input_data = 32'd9;
    while (cnt < 10 && cyc < 100) begin
      @(negedge clk); #1;
      if (vo[0] && ready_in) cnt++;
      cyc++;
    end
    tests++;
    if (cnt != 10) begin
      fails++;
      $display("FAIL mid_reset_reach: got %0d outputs, need 10", cnt);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({ro[0], vo[0], sof[0], eol[0], eof[0]} !== 5'b0 || od[0] !== 32'd0) begin
      fails++;
      $display("FAIL mid_reset: got ro=%b vo=%b flags=%b%b%b d=%0d, need all 0", ro[0], vo[0], sof[0], eol[0], eof[0], od[0]);
    end
    valid_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_stream(0, 1, 0, 1'b0, 5, "after_reset");
  endtask

  initial begin
    test_reset();
    test_latency();
    do_reset(); test_stream(0, 1, 0, 1'b0, 1, "basic");
    do_reset(); test_stream(0, 1, 0, 1'b1, 1, "backpressure");
    do_reset(); test_stream(1, 1, 0, 1'b0, 1, "s1_kw3");
    do_reset(); test_stream(2, 1, 0, 1'b0, 1, "pad_outpad");
    do_reset(); test_stream(0, 1, 3, 1'b0, 1, "valid_gaps");
    do_reset(); test_stream(0, 2, 0, 1'b0, 1, "back_to_back");
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
